// File: rtl/input_debounce_pkg.sv
// rtl/input_debounce_pkg.sv - shared types and constants for the input debouncer
//
// Purpose: holds the debounce FSM state type and the glitch counter width.
// Contents:
//   db_state_t   - ST_LOW / ST_CHK_HIGH / ST_HIGH / ST_CHK_LOW
//   GLITCH_CNT_W - width of the glitch_cnt output
package input_debounce_pkg;

  localparam int GLITCH_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } db_state_t;

endpackage

// File: rtl/input_debounce_sync_chain.sv
// rtl/input_debounce_sync_chain.sv - multi-stage synchronizer for the raw debounce input
//
// Purpose: brings an asynchronous level into the clk domain through STAGES flops.
// Parameters: STAGES (2..4), RESET_VAL (level of every stage after reset)
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   d     - raw asynchronous level
//   q     - synchronized level (last stage)
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - synchronizing debouncer with edge pulses and glitch count
//
// Purpose: synchronizes din, accepts a new level only after STABLE_CYCLES
// consecutive synchronized cycles, and emits one-cycle rise/fall pulses.
// Optional feature macro: INPUT_DEBOUNCE_GLITCH_CNT_EN (glitch counter built
// when defined, glitch_cnt tied to zero otherwise).
// Parameters: SYNC_STAGES (2..4), STABLE_CYCLES (1..255), RESET_VAL
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high reset
//   din        - raw asynchronous level
//   d_out      - debounced level
//   rise       - one-cycle pulse on accepted 0->1
//   fall       - one-cycle pulse on accepted 1->0
//   glitch_cnt - saturating count of rejected transitions
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    din,
  output logic                    d_out,
  output logic                    rise,
  output logic                    fall,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  localparam int             CNT_W     = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam db_state_t      RST_STATE = RESET_VAL ? ST_HIGH : ST_LOW;

  logic             sync_q;
  db_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             d_out_q;
  logic             rise_q;
  logic             fall_q;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (sync_q)
  );

  // cnt_q counts synchronized cycles already spent at the candidate level,
  // so acceptance happens on the edge that sees the STABLE_CYCLES-th one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      d_out_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        ST_LOW: begin
          if (sync_q) begin
            if (STABLE_CYCLES == 1) begin
              state_q <= ST_HIGH;
              d_out_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              state_q <= ST_CHK_HIGH;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        ST_CHK_HIGH: begin
          if (!sync_q) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
            d_out_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!sync_q) begin
            if (STABLE_CYCLES == 1) begin
              state_q <= ST_LOW;
              d_out_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              state_q <= ST_CHK_LOW;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        ST_CHK_LOW: begin
          if (sync_q) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            d_out_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= RST_STATE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign d_out = d_out_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
  logic                    glitch_evt;
  logic [GLITCH_CNT_W-1:0] glitch_q;
  logic [GLITCH_CNT_W-1:0] glitch_d;

  // A glitch is the synchronized input returning to the old level mid-check.
  assign glitch_evt = ((state_q == ST_CHK_HIGH) && !sync_q) ||
                      ((state_q == ST_CHK_LOW)  &&  sync_q);

  always_comb begin
    glitch_d = glitch_q;
    if (glitch_evt && (glitch_q != {GLITCH_CNT_W{1'b1}})) begin
      glitch_d = glitch_q + GLITCH_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// tb/tb_input_debounce.sv - randomized and directed bench for input_debounce
module tb_input_debounce;

  logic       clk;
  logic       reset;
  logic       din;
  logic       d_out0, rise0, fall0;
  logic       d_out1, rise1, fall1;
  logic [7:0] gcnt0, gcnt1;

  int vectors = 0;
  int miss    = 0;

  input_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_VAL(1'b0)) u0 (
    .clk(clk), .reset(reset), .din(din),
    .d_out(d_out0), .rise(rise0), .fall(fall0), .glitch_cnt(gcnt0)
  );

  input_debounce #(.SYNC_STAGES(3), .STABLE_CYCLES(1), .RESET_VAL(1'b1)) u1 (
    .clk(clk), .reset(reset), .din(din),
    .d_out(d_out1), .rise(rise1), .fall(fall1), .glitch_cnt(gcnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
  localparam bit GLITCH_ON = 1'b1;
`else
  localparam bit GLITCH_ON = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the filter sees din as it was SYNC_STAGES edges ago
  // (RESET_VAL if that lies at or before the last reset edge), and accepts a
  // new level once it has differed from the current one STABLE_CYCLES times in a row.
  int  m_stg  [2] = '{2, 3};
  int  m_stab [2] = '{4, 1};
  bit  m_rv   [2] = '{1'b0, 1'b1};
  bit  hist   [0:16383];
  int  edge_n   = 0;
  int  last_rst = -100000;
  bit  mdl_ok   = 0;
  bit  m_lvl  [2];
  bit  m_rise [2];
  bit  m_fall [2];
  int  m_run  [2];
  int  m_gl   [2];

  always @(posedge clk) begin
    bit s;
    hist[edge_n & 16383] = din;
    if (reset) begin
      last_rst = edge_n;
      mdl_ok   = 1;
    end
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = 0;
      m_fall[i] = 0;
      if (reset) begin
        m_lvl[i] = m_rv[i];
        m_run[i] = 0;
        m_gl[i]  = 0;
      end else if (mdl_ok) begin
        if (edge_n - m_stg[i] > last_rst) s = hist[(edge_n - m_stg[i]) & 16383];
        else s = m_rv[i];
        if (s != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == m_stab[i]) begin
            m_lvl[i] = s;
            if (s) m_rise[i] = 1; else m_fall[i] = 1;
            m_run[i] = 0;
          end
        end else begin
          if (m_run[i] > 0 && m_gl[i] < 255) m_gl[i]++;
          m_run[i] = 0;
        end
      end
    end
    edge_n++;
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("u0.d_out", {31'd0, d_out0}, {31'd0, m_lvl[0]});
      chk("u0.rise",  {31'd0, rise0},  {31'd0, m_rise[0]});
      chk("u0.fall",  {31'd0, fall0},  {31'd0, m_fall[0]});
      chk("u0.glitch_cnt", {24'd0, gcnt0}, GLITCH_ON ? m_gl[0] : 0);
      chk("u1.d_out", {31'd0, d_out1}, {31'd0, m_lvl[1]});
      chk("u1.rise",  {31'd0, rise1},  {31'd0, m_rise[1]});
      chk("u1.fall",  {31'd0, fall1},  {31'd0, m_fall[1]});
      chk("u1.glitch_cnt", {24'd0, gcnt1}, GLITCH_ON ? m_gl[1] : 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hold;
    reset = 1'b1;
    din   = 1'b1;

    // Reset with din high: outputs pinned at reset values.
    repeat (3) cyc();
    chk("rst.d_out", {31'd0, d_out0}, 0);
    chk("rst.rise",  {31'd0, rise0}, 0);
    chk("rst.fall",  {31'd0, fall0}, 0);
    chk("rst.glitch", {24'd0, gcnt0}, 0);
    chk("rst.u1.d_out", {31'd0, d_out1}, 1);
    reset = 1'b0;
    repeat (5) cyc();
    chk("rel.rise_e5", {31'd0, rise0}, 0);
    cyc();
    chk("rel.rise_e6", {31'd0, rise0}, 1);
    chk("rel.d_out_e6", {31'd0, d_out0}, 1);
    cyc();
    chk("rel.rise_e7", {31'd0, rise0}, 0);

    // 1->0: u1 (3 stages, 1 cycle) falls after edge 3, u0 after edge 5.
    din = 1'b0;
    repeat (3) cyc();
    chk("u1.fall_e2", {31'd0, fall1}, 0);
    cyc();
    chk("u1.fall_e3", {31'd0, fall1}, 1);
    chk("u1.d_out_e3", {31'd0, d_out1}, 0);
    cyc();
    chk("u0.fall_e4", {31'd0, fall0}, 0);
    cyc();
    chk("u0.fall_e5", {31'd0, fall0}, 1);
    chk("u0.d_out_e5", {31'd0, d_out0}, 0);
    repeat (4) cyc();

    // 0->1 from stable low.
    din = 1'b1;
    repeat (5) cyc();
    chk("u0.rise_e4", {31'd0, rise0}, 0);
    chk("u0.d_out_e4", {31'd0, d_out0}, 0);
    cyc();
    chk("u0.rise_e5", {31'd0, rise0}, 1);
    cyc();
    chk("u0.rise_e6", {31'd0, rise0}, 0);
    chk("u0.d_out_e6", {31'd0, d_out0}, 1);
    din = 1'b0;
    repeat (8) cyc();

    // Two-cycle excursion is rejected as one glitch.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (3) cyc();
    din = 1'b1;
    repeat (2) cyc();
    din = 1'b0;
    repeat (6) cyc();
    chk("glitch1.d_out", {31'd0, d_out0}, 0);
    chk("glitch1.cnt", {24'd0, gcnt0}, GLITCH_ON ? 1 : 0);

    // 300 single-cycle pulses saturate the counter.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int n = 0; n < 300; n++) begin
      din = 1'b1;
      cyc();
      din = 1'b0;
      cyc();
    end
    repeat (6) cyc();
    chk("sat.d_out", {31'd0, d_out0}, 0);
    chk("sat.cnt", {24'd0, gcnt0}, GLITCH_ON ? 255 : 0);

    // Reset on the acceptance edge wins.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    din   = 1'b1;
    repeat (5) cyc();
    reset = 1'b1;
    cyc();
    chk("rstacc.d_out", {31'd0, d_out0}, 0);
    chk("rstacc.rise",  {31'd0, rise0}, 0);
    reset = 1'b0;

    // Randomized runs of varying length with occasional resets.
    hold = 0;
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (hold == 0) begin
        din  = ~din;
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 10);
      end
      hold--;
      cyc();
    end
    reset = 1'b0;
    repeat (10) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
